// File: rtl/scarv_cop_palu_issue.sv
// Issue stage for the packed-ALU coprocessor: latches one decoded instruction, reads CPR operands,
// hands them to the PALU, waits for completion (or times out) and writes the result back.
module scarv_cop_palu_issue #(
  parameter int unsigned EXEC_TIMEOUT = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        id_valid,
  output logic        id_ready,
  input  logic [2:0]  id_class,
  input  logic [3:0]  id_subclass,
  input  logic [2:0]  id_pw,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_gpr_rs1,
  input  logic [3:0]  id_crs1,
  input  logic [3:0]  id_crs2,
  input  logic [3:0]  id_crs3,
  input  logic [3:0]  id_crd,

  output logic [3:0]  cpr_rs1_addr,
  output logic [3:0]  cpr_rs2_addr,
  output logic [3:0]  cpr_rs3_addr,
  input  logic [31:0] cpr_rs1_rdata,
  input  logic [31:0] cpr_rs2_rdata,
  input  logic [31:0] cpr_rs3_rdata,

  output logic        palu_ivalid,
  input  logic        palu_idone,
  output logic [31:0] gpr_rs1,
  output logic [31:0] palu_rs1,
  output logic [31:0] palu_rs2,
  output logic [31:0] palu_rs3,
  output logic [31:0] id_imm_o,
  output logic [2:0]  id_pw_o,
  output logic [2:0]  id_class_o,
  output logic [3:0]  id_subclass_o,

  input  logic [3:0]  palu_cpr_rd_ben,
  input  logic [31:0] palu_cpr_rd_wdata,

  output logic [3:0]  cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [31:0] cpr_wdata,

  output logic        insn_done,
  output logic        insn_err,
  output logic [7:0]  exec_cycles
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(EXEC_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

  state_t      state_q;
  logic [3:0]  crd_q;
  logic [7:0]  cnt_q;

  // All outputs are registered; cpr_wen and insn_done are single-cycle WB pulses.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q       <= StIdle;
      id_ready      <= 1'b0;
      palu_ivalid   <= 1'b0;
      cpr_wen       <= 4'h0;
      cpr_waddr     <= 4'h0;
      cpr_wdata     <= 32'h0;
      insn_done     <= 1'b0;
      insn_err      <= 1'b0;
      exec_cycles   <= 8'h0;
      cnt_q         <= 8'h0;
      crd_q         <= 4'h0;
      cpr_rs1_addr  <= 4'h0;
      cpr_rs2_addr  <= 4'h0;
      cpr_rs3_addr  <= 4'h0;
      gpr_rs1       <= 32'h0;
      palu_rs1      <= 32'h0;
      palu_rs2      <= 32'h0;
      palu_rs3      <= 32'h0;
      id_imm_o      <= 32'h0;
      id_pw_o       <= 3'h0;
      id_class_o    <= 3'h0;
      id_subclass_o <= 4'h0;
    end else begin
      cpr_wen   <= 4'h0;
      insn_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (id_valid && id_ready) begin
            id_ready      <= 1'b0;
            cpr_rs1_addr  <= id_crs1;
            cpr_rs2_addr  <= id_crs2;
            cpr_rs3_addr  <= id_crs3;
            crd_q         <= id_crd;
            gpr_rs1       <= id_gpr_rs1;
            id_imm_o      <= id_imm;
            id_pw_o       <= id_pw;
            id_class_o    <= id_class;
            id_subclass_o <= id_subclass;
            state_q       <= StRead;
          end else begin
            id_ready <= 1'b1;
          end
        end
        StRead: begin
          palu_rs1    <= cpr_rs1_rdata;
          palu_rs2    <= cpr_rs2_rdata;
          palu_rs3    <= cpr_rs3_rdata;
          palu_ivalid <= 1'b1;
          cnt_q       <= 8'd1;
          state_q     <= StExec;
        end
        StExec: begin
          if (palu_idone) begin
            palu_ivalid <= 1'b0;
            cpr_wen     <= palu_cpr_rd_ben;
            cpr_wdata   <= palu_cpr_rd_wdata;
            cpr_waddr   <= crd_q;
            insn_done   <= 1'b1;
            insn_err    <= 1'b0;
            exec_cycles <= cnt_q;
            state_q     <= StWb;
          end else if (cnt_q == TIMEOUT_CNT) begin
            // Timed out: complete with no write and flag the error.
            palu_ivalid <= 1'b0;
            cpr_wen     <= 4'h0;
            cpr_waddr   <= crd_q;
            insn_done   <= 1'b1;
            insn_err    <= 1'b1;
            exec_cycles <= cnt_q;
            state_q     <= StWb;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWb: begin
          insn_err <= 1'b0;
          id_ready <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// Scoreboard bench for scarv_cop_palu_issue: a CPR file and PALU model surround the DUT, expected
// writebacks and operands are queued at issue and checked when the DUT reaches EXEC and WB.
module tb_scarv_cop_palu_issue;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [2:0]  id_class = '0;
  logic [3:0]  id_subclass = '0;
  logic [2:0]  id_pw = '0;
  logic [31:0] id_imm = '0;
  logic [31:0] id_gpr_rs1 = '0;
  logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crs3 = '0, id_crd = '0;
  logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr;
  logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata;
  logic        palu_ivalid;
  logic        palu_idone = 1'b0;
  logic [31:0] gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm_o;
  logic [2:0]  id_pw_o, id_class_o;
  logic [3:0]  id_subclass_o;
  logic [3:0]  palu_cpr_rd_ben = '0;
  logic [31:0] palu_cpr_rd_wdata = '0;
  logic [3:0]  cpr_wen, cpr_waddr;
  logic [31:0] cpr_wdata;
  logic        insn_done, insn_err;
  logic [7:0]  exec_cycles;

  // Short-timeout instance, PALU never completes.
  logic        t_valid = 1'b0;
  logic        t_id_ready, t_palu_ivalid, t_insn_done, t_insn_err;
  logic [3:0]  t_rs1_addr, t_rs2_addr, t_rs3_addr, t_subclass_o, t_cpr_wen, t_cpr_waddr;
  logic [31:0] t_gpr_rs1, t_rs1, t_rs2, t_rs3, t_imm_o, t_cpr_wdata;
  logic [2:0]  t_pw_o, t_class_o;
  logic [7:0]  t_exec_cycles;

  always #5 g_clk = ~g_clk;

  scarv_cop_palu_issue u_dut (
    .g_clk(g_clk), .g_reset(g_reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm),
    .id_gpr_rs1(id_gpr_rs1), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
    .id_crd(id_crd), .cpr_rs1_addr(cpr_rs1_addr), .cpr_rs2_addr(cpr_rs2_addr),
    .cpr_rs3_addr(cpr_rs3_addr), .cpr_rs1_rdata(cpr_rs1_rdata), .cpr_rs2_rdata(cpr_rs2_rdata),
    .cpr_rs3_rdata(cpr_rs3_rdata), .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
    .gpr_rs1(gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
    .id_imm_o(id_imm_o), .id_pw_o(id_pw_o), .id_class_o(id_class_o),
    .id_subclass_o(id_subclass_o), .palu_cpr_rd_ben(palu_cpr_rd_ben),
    .palu_cpr_rd_wdata(palu_cpr_rd_wdata), .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr),
    .cpr_wdata(cpr_wdata), .insn_done(insn_done), .insn_err(insn_err),
    .exec_cycles(exec_cycles)
  );

  scarv_cop_palu_issue #(.EXEC_TIMEOUT(4)) u_to (
    .g_clk(g_clk), .g_reset(g_reset), .id_valid(t_valid), .id_ready(t_id_ready),
    .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm),
    .id_gpr_rs1(id_gpr_rs1), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
    .id_crd(id_crd), .cpr_rs1_addr(t_rs1_addr), .cpr_rs2_addr(t_rs2_addr),
    .cpr_rs3_addr(t_rs3_addr), .cpr_rs1_rdata(32'h0), .cpr_rs2_rdata(32'h0),
    .cpr_rs3_rdata(32'h0), .palu_ivalid(t_palu_ivalid), .palu_idone(1'b0),
    .gpr_rs1(t_gpr_rs1), .palu_rs1(t_rs1), .palu_rs2(t_rs2), .palu_rs3(t_rs3),
    .id_imm_o(t_imm_o), .id_pw_o(t_pw_o), .id_class_o(t_class_o),
    .id_subclass_o(t_subclass_o), .palu_cpr_rd_ben(4'hF), .palu_cpr_rd_wdata(32'h0),
    .cpr_wen(t_cpr_wen), .cpr_waddr(t_cpr_waddr), .cpr_wdata(t_cpr_wdata),
    .insn_done(t_insn_done), .insn_err(t_insn_err), .exec_cycles(t_exec_cycles)
  );

  // CPR file model: combinational read, byte-enabled write on the clock edge.
  logic [31:0] cpr [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge g_clk) begin
    if (pl_en) cpr[pl_addr] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (cpr_wen[b]) cpr[cpr_waddr][8*b +: 8] <= cpr_wdata[8*b +: 8];
  end
  assign cpr_rs1_rdata = cpr[cpr_rs1_addr];
  assign cpr_rs2_rdata = cpr[cpr_rs2_addr];
  assign cpr_rs3_rdata = cpr[cpr_rs3_addr];

  typedef struct {
    logic [3:0]  wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic [7:0]  ecyc;
    int          acc;
    int          lat;
    logic [31:0] rs1, rs2, rs3, imm, gpr;
    logic [9:0]  fld;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] shadow [16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          plan_lat = 0;
  logic        stray = 1'b0;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PALU model plus EXEC/WB checking against the scoreboard.
  int          ecnt = 0;
  int          last_ecnt = 0;
  logic [31:0] s_rs1, s_rs2, s_rs3;
  always @(negedge g_clk) begin
    if (g_reset) begin
      ecnt = 0;
      palu_idone = 1'b0;
    end else begin
      if (palu_ivalid) begin
        ecnt++;
        check_val("wen_in_exec", 32'(cpr_wen), 32'h0);
        if (ecnt == 1) begin
          if (sbq.size() == 0) check_val("ivalid_unexpected", 32'(palu_ivalid), 32'h0);
          else begin
            check_val("op_rs1", palu_rs1, sbq[0].rs1);
            check_val("op_rs2", palu_rs2, sbq[0].rs2);
            check_val("op_rs3", palu_rs3, sbq[0].rs3);
            check_val("op_imm", id_imm_o, sbq[0].imm);
            check_val("op_gpr", gpr_rs1, sbq[0].gpr);
            check_val("op_fld", 32'({id_pw_o, id_subclass_o, id_class_o}), 32'(sbq[0].fld));
          end
          s_rs1 = palu_rs1;
          s_rs2 = palu_rs2;
          s_rs3 = palu_rs3;
        end else begin
          check_val("op_stable", palu_rs1 ^ palu_rs2 ^ palu_rs3, s_rs1 ^ s_rs2 ^ s_rs3);
        end
      end else begin
        if (ecnt != 0) last_ecnt = ecnt;
        ecnt = 0;
      end
      if (insn_done) begin
        if (sbq.size() == 0) check_val("done_unexpected", 32'(insn_done), 32'h0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check_val("wb_wen", 32'(cpr_wen), 32'(e.wen));
          check_val("wb_waddr", 32'(cpr_waddr), 32'(e.waddr));
          if (e.wen != 4'h0) check_val("wb_wdata", cpr_wdata, e.wdata);
          check_val("wb_err", 32'(insn_err), 32'(e.err));
          check_val("wb_exec_cycles", 32'(exec_cycles), 32'(e.ecyc));
          check_val("wb_latency", 32'(cyc - e.acc), 32'(e.lat));
          check_val("ivalid_cycles", 32'(last_ecnt), 32'(e.ecyc));
        end
      end
      palu_idone = stray || (palu_ivalid && ecnt == plan_lat);
    end
  end

  task automatic issue(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                       input logic [3:0] crd, input int lat, input logic [3:0] ben,
                       input logic [31:0] wd, input logic [31:0] imm, input logic [31:0] gpr);
    exp_t e;
    int   n;
    logic tmo;
    n = 0;
    @(negedge g_clk);
    while (!id_ready && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    check_val("accept_ready", 32'(id_ready), 32'h1);
    if (!id_ready) return;
    tmo = !(lat >= 1 && lat <= 255);
    plan_lat = lat;
    palu_cpr_rd_ben = ben;
    palu_cpr_rd_wdata = wd;
    id_crs1 = c1; id_crs2 = c2; id_crs3 = c3; id_crd = crd;
    id_imm = imm; id_gpr_rs1 = gpr;
    id_class = imm[2:0]; id_subclass = imm[6:3]; id_pw = imm[9:7];
    id_valid = 1'b1;
    last_acc = cyc;
    e.wen = tmo ? 4'h0 : ben;
    e.waddr = crd;
    e.wdata = wd;
    e.err = tmo;
    e.ecyc = tmo ? 8'd255 : 8'(lat);
    e.acc = cyc;
    e.lat = 2 + int'(e.ecyc);
    e.rs1 = shadow[c1]; e.rs2 = shadow[c2]; e.rs3 = shadow[c3];
    e.imm = imm; e.gpr = gpr; e.fld = imm[9:0];
    for (int b = 0; b < 4; b++)
      if (e.wen[b]) shadow[crd][8*b +: 8] = wd[8*b +: 8];
    sbq.push_back(e);
    @(negedge g_clk);
    id_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sbq.size() == 0 && id_ready) && n < 400) begin
      @(negedge g_clk);
      n++;
    end
    check_val("drain", 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    int a1;
    int n;
    int tcnt;
    #12;
    check_val("rst_id_ready", 32'(id_ready), 32'h0);
    check_val("rst_ivalid", 32'(palu_ivalid), 32'h0);
    check_val("rst_wen", 32'(cpr_wen), 32'h0);
    check_val("rst_done", 32'({insn_done, insn_err}), 32'h0);
    check_val("rst_exec_cycles", 32'(exec_cycles), 32'h0);
    check_val("rst_regs", palu_rs1 | palu_rs2 | palu_rs3 | id_imm_o | cpr_wdata, 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    check_val("ready_after_rst", 32'(id_ready), 32'h1);

    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1;
      pl_addr = 4'(i);
      pl_data = (i == 1) ? 32'h5 : (i == 2) ? 32'h3 : 32'(i) * 32'h1111_1111;
      shadow[i] = pl_data;
      @(negedge g_clk);
    end
    pl_en = 1'b0;

    // ADD: single-cycle PALU
    issue(4'd1, 4'd2, 4'd0, 4'd4, 1, 4'hF, 32'h8, 32'h0000_0155, 32'hA5A5_0001);
    wait_idle();
    // MUL: five EXEC cycles
    issue(4'd4, 4'd1, 4'd2, 4'd5, 5, 4'hF, 32'h0000_0040, 32'h0000_02AA, 32'h1234_5678);
    wait_idle();
    // CMOV untaken
    issue(4'd5, 4'd6, 4'd7, 4'd7, 2, 4'h0, 32'hFFFF_FFFF, 32'h0000_0321, 32'h0);
    wait_idle();
    // back-to-back dependent pair, then a partial-byte write read back
    issue(4'd0, 4'd0, 4'd0, 4'd3, 1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0011, 32'h1);
    a1 = last_acc;
    issue(4'd3, 4'd4, 4'd5, 4'd6, 1, 4'b0101, 32'h1122_3344, 32'h0000_0022, 32'h2);
    check_val("b2b_gap", 32'(last_acc - a1), 32'd4);
    issue(4'd6, 4'd3, 4'd0, 4'd8, 3, 4'hF, 32'hCAFE_0001, 32'h0000_0033, 32'h3);
    wait_idle();

    // stray completion while idle must be ignored
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      check_val("stray_ready", 32'(id_ready), 32'h1);
      check_val("stray_ivalid", 32'(palu_ivalid), 32'h0);
    end
    stray = 1'b0;
    @(negedge g_clk);

    // reset in the middle of EXEC
    issue(4'd1, 4'd2, 4'd3, 4'd10, 0, 4'hF, 32'h5555_5555, 32'h0000_0044, 32'h4);
    n = 0;
    while (!palu_ivalid && n < 10) begin
      @(negedge g_clk);
      n++;
    end
    check_val("rst_reach_exec", 32'(palu_ivalid), 32'h1);
    @(negedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b1;
    #1;
    check_val("mid_rst_ivalid", 32'(palu_ivalid), 32'h0);
    check_val("mid_rst_wen", 32'(cpr_wen), 32'h0);
    check_val("mid_rst_done", 32'(insn_done), 32'h0);
    check_val("mid_rst_ready", 32'(id_ready), 32'h0);
    check_val("mid_rst_exec_cycles", 32'(exec_cycles), 32'h0);
    sbq.delete();
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    check_val("ready_after_mid_rst", 32'(id_ready), 32'h1);
    issue(4'd3, 4'd6, 4'd8, 4'd9, 2, 4'hF, 32'h0BAD_F00D, 32'h0000_0155, 32'h5);
    wait_idle();

    // timeout on the EXEC_TIMEOUT=4 instance
    t_valid = 1'b1;
    @(negedge g_clk);
    t_valid = 1'b0;
    n = 0;
    tcnt = 0;
    while (!t_insn_done && n < 40) begin
      @(negedge g_clk);
      if (t_palu_ivalid) tcnt++;
      n++;
    end
    check_val("to_done", 32'(t_insn_done), 32'h1);
    check_val("to_wen", 32'(t_cpr_wen), 32'h0);
    check_val("to_err", 32'(t_insn_err), 32'h1);
    check_val("to_exec_cycles", 32'(t_exec_cycles), 32'd4);
    check_val("to_ivalid_cycles", 32'(tcnt), 32'd4);

    @(negedge g_clk);
    for (int i = 0; i < 16; i++) check_val("cpr_final", cpr[i], shadow[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scarv_cop_palu_issue.md
SCARV_COP_PALU_ISSUE -- requirements
Module: scarv_cop_palu_issue

Interface
REQ-001 SHALL have parameter: EXEC_TIMEOUT, 255, max cycles in EXEC waiting for palu_idone (1..255).
REQ-002 SHALL have port: g_clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: g_reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: id_valid in 1 / id_ready out 1, instruction handshake from decode.
REQ-005 SHALL have ports: id_class in 3, id_subclass in 4, id_pw in 3, id_imm in 32, id_gpr_rs1 in 32, decoded fields.
REQ-006 SHALL have ports: id_crs1, id_crs2, id_crs3, id_crd  in  4 each, CPR source and destination indices.
REQ-007 SHALL have ports: cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr  out  4 each; cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata  in  32 each, combinational CPR read data.
REQ-008 SHALL have ports: palu_ivalid out 1, palu_idone in 1, PALU request and completion.
REQ-009 SHALL have ports: gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm_o  out  32; id_pw_o out 3; id_class_o out 3; id_subclass_o out 4; operands to the PALU.
REQ-010 SHALL have ports: palu_cpr_rd_ben in 4, palu_cpr_rd_wdata in 32, PALU writeback.
REQ-011 SHALL have ports: cpr_wen out 4, cpr_waddr out 4, cpr_wdata out 32, CPR byte-enabled write port.
REQ-012 SHALL have ports: insn_done out 1, insn_err out 1, exec_cycles out 8, completion pulse, timeout flag, EXEC cycle count of the last instruction.

Function
REQ-013 SHALL implement FSM states IDLE, READ, EXEC, WB; exactly one instruction in flight.
REQ-014 IDLE: id_ready=1; id_valid&&id_ready latches all id_* fields, goes to READ; otherwise stays.
REQ-015 READ: cpr_rsN_addr = latched crsN; cpr_rsN_rdata captured into operand registers at cycle end; goes to EXEC. Outside READ, addresses hold their last value.
REQ-016 EXEC: palu_ivalid=1; all PALU operand outputs come from registers and are stable for the whole of EXEC.
REQ-017 EXEC: in the cycle palu_idone=1, palu_cpr_rd_ben and palu_cpr_rd_wdata are captured; goes to WB. palu_ivalid drops in the following cycle.
REQ-018 EXEC: cycle counter starts at 1 on the first EXEC cycle and increments each cycle. If the count equals EXEC_TIMEOUT with palu_idone=0: ben captured as 0, err flag set, goes to WB.
REQ-019 WB lasts exactly one cycle: cpr_wen=captured ben, cpr_waddr=latched crd, cpr_wdata=captured wdata; insn_done=1; insn_err=err flag; exec_cycles updated to counter value; goes to IDLE.
REQ-020 cpr_wen SHALL be 4'h0 in every state except WB. A WB with ben=0 (e.g. untaken cmov) writes nothing but still pulses insn_done.
REQ-021 Minimum latency: accept at cycle N, EXEC at N+2, WB at N+3, id_ready=1 again at N+4.
REQ-022 No read-after-write hazard exists: the WB write completes before the next READ, so back-to-back dependent instructions see updated data.
REQ-023 palu_idone seen outside EXEC SHALL be ignored.
REQ-024 exec_cycles SHALL saturate at 255.

Reset
REQ-025 While g_reset=1, asynchronously: state=IDLE, id_ready=0, palu_ivalid=0, cpr_wen=0, insn_done=0, insn_err=0, exec_cycles=0, all operand/address/data registers=0.
REQ-026 Reset asserted in any state (including EXEC with palu_ivalid=1) SHALL abort the instruction with no CPR write. id_ready=1 from the first edge after deassertion.

Verification
REQ-027 ADD.PX: CPR1=0x00000005, CPR2=0x00000003, crd=4, PALU idone same cycle with ben=F, wdata=0x8 -> WB at N+3: cpr_wen=F, cpr_waddr=4, cpr_wdata=0x00000008, insn_done=1, exec_cycles=1.
REQ-028 MUL.PX: idone on the 5th EXEC cycle -> palu_ivalid high for exactly 5 cycles with operands unchanged; exec_cycles=5.
REQ-029 CMOV untaken: PALU returns ben=0 -> cpr_wen=0 in WB, insn_done=1, insn_err=0.
REQ-030 Timeout: EXEC_TIMEOUT=4, idone held 0 -> WB after the 4th EXEC cycle; cpr_wen=0, insn_err=1, exec_cycles=4.
REQ-031 Back-to-back: insn A writes CPR3=0xDEADBEEF, insn B reads crs1=3 -> B's palu_rs1=0xDEADBEEF; the second accept happens 4 cycles after the first.
REQ-032 Reset pulse during EXEC -> palu_ivalid=0 and cpr_wen=0 immediately, no insn_done; the next instruction completes normally.
